ahb_bus_matrix_outputstage_arb: RTL and testbench

- Output stage for one bus-matrix master-interface port; the counterpart of the per-input-stage decoders.
- Takes address-phase requests from 3 input stages (S0..S2) and arbitrates round-robin with burst and lock retention.
- Drives the selected transfer onto the AHB master port and returns per-input active_op_i so each decoder knows when its transfer owns the port.
- Tracks the data-phase owner to steer HWDATAM.

---
 rtl/ahb_bus_matrix_outputstage_arb.sv | 167 ++++++++++++++++
 tb/tb_ahb_bus_matrix_outputstage_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_matrix_outputstage_arb.sv
// Bus-matrix output stage: round-robin arbitration of three input stages onto one
// AHB master port, with burst/lock retention and data-phase owner tracking.
module ahb_bus_matrix_outputstage_arb (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        sel_op_0,
  input  logic        sel_op_1,
  input  logic        sel_op_2,
  input  logic [31:0] addr_op_0,
  input  logic [31:0] addr_op_1,
  input  logic [31:0] addr_op_2,
  input  logic [1:0]  trans_op_0,
  input  logic [1:0]  trans_op_1,
  input  logic [1:0]  trans_op_2,
  input  logic        write_op_0,
  input  logic        write_op_1,
  input  logic        write_op_2,
  input  logic [2:0]  size_op_0,
  input  logic [2:0]  size_op_1,
  input  logic [2:0]  size_op_2,
  input  logic [2:0]  burst_op_0,
  input  logic [2:0]  burst_op_1,
  input  logic [2:0]  burst_op_2,
  input  logic [3:0]  prot_op_0,
  input  logic [3:0]  prot_op_1,
  input  logic [3:0]  prot_op_2,
  input  logic        mastlock_op_0,
  input  logic        mastlock_op_1,
  input  logic        mastlock_op_2,
  input  logic [31:0] wdata_op_0,
  input  logic [31:0] wdata_op_1,
  input  logic [31:0] wdata_op_2,
  output logic        active_op_0,
  output logic        active_op_1,
  output logic        active_op_2,
  input  logic        HREADYM,
  output logic        HSELM,
  output logic [31:0] HADDRM,
  output logic [1:0]  HTRANSM,
  output logic        HWRITEM,
  output logic [2:0]  HSIZEM,
  output logic [2:0]  HBURSTM,
  output logic [3:0]  HPROTM,
  output logic        HMASTLOCKM,
  output logic [31:0] HWDATAM
);

  localparam int         NUM_IN = 3;
  localparam logic [1:0] NONE   = 2'b11;

  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] write;
  logic [NUM_IN-1:0] lock;
  logic [31:0]       addr  [NUM_IN];
  logic [1:0]        trans [NUM_IN];
  logic [2:0]        size  [NUM_IN];
  logic [2:0]        burst [NUM_IN];
  logic [3:0]        prot  [NUM_IN];
  logic [31:0]       wdata [NUM_IN];

  assign sel   = {sel_op_2, sel_op_1, sel_op_0};
  assign write = {write_op_2, write_op_1, write_op_0};
  assign lock  = {mastlock_op_2, mastlock_op_1, mastlock_op_0};
  assign addr  = '{addr_op_0, addr_op_1, addr_op_2};
  assign trans = '{trans_op_0, trans_op_1, trans_op_2};
  assign size  = '{size_op_0, size_op_1, size_op_2};
  assign burst = '{burst_op_0, burst_op_1, burst_op_2};
  assign prot  = '{prot_op_0, prot_op_1, prot_op_2};
  assign wdata = '{wdata_op_0, wdata_op_1, wdata_op_2};

  logic [1:0] addr_in_port_q, addr_in_port_d;
  logic [1:0] data_in_port_q, data_in_port_d;
  logic [1:0] last_grant_q, last_grant_d;

  logic        own_sel, own_write, own_lock;
  logic [31:0] own_addr;
  logic [1:0]  own_trans;
  logic [2:0]  own_size, own_burst;
  logic [3:0]  own_prot;
  logic        hold;
  logic [1:0]  next_port;

  // Scan order starts just after the last grant, so the last winner ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [1:0] lg, input logic [NUM_IN-1:0] req);
    logic [1:0] c0, c1, c2;
    case (lg)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    rr_pick = NONE;
    if (req[c2]) rr_pick = c2;
    if (req[c1]) rr_pick = c1;
    if (req[c0]) rr_pick = c0;
  endfunction

  always_comb begin
    own_sel   = 1'b0;
    own_write = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_trans = 2'b00;
    own_size  = '0;
    own_burst = '0;
    own_prot  = '0;
    if (addr_in_port_q != NONE) begin
      own_sel   = sel[addr_in_port_q];
      own_write = write[addr_in_port_q];
      own_lock  = lock[addr_in_port_q];
      own_addr  = addr[addr_in_port_q];
      own_trans = trans[addr_in_port_q];
      own_size  = size[addr_in_port_q];
      own_burst = burst[addr_in_port_q];
      own_prot  = prot[addr_in_port_q];
    end
  end

  assign HSELM      = own_sel;
  assign HTRANSM    = own_sel ? own_trans : 2'b00;
  assign HADDRM     = own_addr;
  assign HWRITEM    = own_write;
  assign HSIZEM     = own_size;
  assign HBURSTM    = own_burst;
  assign HPROTM     = own_prot;
  assign HMASTLOCKM = own_lock;

  assign active_op_0 = (addr_in_port_q == 2'd0);
  assign active_op_1 = (addr_in_port_q == 2'd1);
  assign active_op_2 = (addr_in_port_q == 2'd2);

  // BUSY/SEQ keep a burst on the port; a locked owner keeps it through IDLE gaps too.
  assign hold = (addr_in_port_q != NONE) & own_sel &
                (own_trans == 2'b01 | own_trans == 2'b11 | own_lock);

  always_comb begin
    next_port = hold ? addr_in_port_q : rr_pick(last_grant_q, sel);
  end

  always_comb begin
    addr_in_port_d = addr_in_port_q;
    data_in_port_d = data_in_port_q;
    last_grant_d   = last_grant_q;
    if (HREADYM) begin
      addr_in_port_d = next_port;
      if (next_port != NONE) last_grant_d = next_port;
      data_in_port_d = (HSELM & HTRANSM[1]) ? addr_in_port_q : NONE;
    end
  end

  always_comb begin
    HWDATAM = '0;
    if (data_in_port_q != NONE) HWDATAM = wdata[data_in_port_q];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port_q <= NONE;
      data_in_port_q <= NONE;
      last_grant_q   <= 2'd2;
    end else begin
      addr_in_port_q <= addr_in_port_d;
      data_in_port_q <= data_in_port_d;
      last_grant_q   <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_matrix_outputstage_arb.sv
// Directed scoreboard bench for the bus-matrix output-stage arbiter.
module tb_ahb_bus_matrix_outputstage_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HREADYM = 1'b1;
  logic [2:0]  sel, wr, lk;
  logic [1:0]  tr [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [2:0]  sz [3];
  logic [2:0]  bu [3];
  logic [3:0]  pr [3];

  logic        a0, a1, a2;
  logic        HSELM, HWRITEM, HMASTLOCKM;
  logic [31:0] HADDRM, HWDATAM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;

  ahb_bus_matrix_outputstage_arb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .sel_op_0(sel[0]), .sel_op_1(sel[1]), .sel_op_2(sel[2]),
    .addr_op_0(ad[0]), .addr_op_1(ad[1]), .addr_op_2(ad[2]),
    .trans_op_0(tr[0]), .trans_op_1(tr[1]), .trans_op_2(tr[2]),
    .write_op_0(wr[0]), .write_op_1(wr[1]), .write_op_2(wr[2]),
    .size_op_0(sz[0]), .size_op_1(sz[1]), .size_op_2(sz[2]),
    .burst_op_0(bu[0]), .burst_op_1(bu[1]), .burst_op_2(bu[2]),
    .prot_op_0(pr[0]), .prot_op_1(pr[1]), .prot_op_2(pr[2]),
    .mastlock_op_0(lk[0]), .mastlock_op_1(lk[1]), .mastlock_op_2(lk[2]),
    .wdata_op_0(wd[0]), .wdata_op_1(wd[1]), .wdata_op_2(wd[2]),
    .active_op_0(a0), .active_op_1(a1), .active_op_2(a2),
    .HREADYM(HREADYM), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
    .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM)
  );

  always #5 HCLK = ~HCLK;

  localparam int S_ACT = 0, S_SEL = 1, S_TR = 2, S_ADDR = 3, S_WD = 4, S_LK = 5, S_PROT = 6, S_WR = 7;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_ACT:   observe = {29'd0, a2, a1, a0};
      S_SEL:   observe = {31'd0, HSELM};
      S_TR:    observe = {30'd0, HTRANSM};
      S_ADDR:  observe = HADDRM;
      S_WD:    observe = HWDATAM;
      S_LK:    observe = {31'd0, HMASTLOCKM};
      S_PROT:  observe = {28'd0, HPROTM};
      S_WR:    observe = {31'd0, HWRITEM};
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic grant(input string tag, input logic [2:0] act, input logic [1:0] htr, input logic [31:0] a);
    push({tag, "_act"}, S_ACT, {29'd0, act});
    push({tag, "_htrans"}, S_TR, {30'd0, htr});
    push({tag, "_haddr"}, S_ADDR, a);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    drain();
  endtask

  task automatic clr();
    sel = '0; wr = '0; lk = '0;
    for (int i = 0; i < 3; i++) begin
      tr[i] = 2'b00; ad[i] = '0; wd[i] = '0;
      sz[i] = 3'b010; bu[i] = 3'b000; pr[i] = 4'h0;
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HREADYM = 1'b1;
    clr();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic req(input int p, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, input logic l);
    sel[p] = 1'b1; tr[p] = t; ad[p] = a; wd[p] = d; wr[p] = 1'b1; lk[p] = l;
  endtask

  logic [1:0]  lock_tr [5];
  logic [31:0] lock_ad [5];

  initial begin
    clr();
    #1;
    HRESETn = 1'b0;
    #1;
    push("rst_act", S_ACT, 0); push("rst_hsel", S_SEL, 0); push("rst_htrans", S_TR, 0);
    push("rst_hwdata", S_WD, 0); push("rst_hlock", S_LK, 0); push("rst_haddr", S_ADDR, 0);
    drain();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // single NONSEQ write from S0
    req(0, 2'b10, 32'h0001_0000, 32'hA0A0_0001, 1'b0);
    pr[0] = 4'h3;
    grant("t1", 3'b001, 2'b10, 32'h0001_0000);
    push("t1_hsel", S_SEL, 1); push("t1_prot", S_PROT, 3); push("t1_hwrite", S_WR, 1);
    tick();
    push("t1_hwdata", S_WD, 32'hA0A0_0001);
    tick();
    sel[0] = 1'b0; tr[0] = 2'b00;
    push("t1_idle_act", S_ACT, 0); push("t1_idle_hwdata", S_WD, 0);
    tick();

    // simultaneous requests rotate S0, S1, S2, S0
    do_reset();
    req(0, 2'b10, 32'h0000_1000, 32'hD000_0000, 1'b0);
    req(1, 2'b10, 32'h0000_2000, 32'hD000_0001, 1'b0);
    req(2, 2'b10, 32'h0000_3000, 32'hD000_0002, 1'b0);
    grant("t2_s0", 3'b001, 2'b10, 32'h0000_1000);
    tick();
    grant("t2_s1", 3'b010, 2'b10, 32'h0000_2000); push("t2_wd0", S_WD, 32'hD000_0000);
    tick();
    grant("t2_s2", 3'b100, 2'b10, 32'h0000_3000); push("t2_wd1", S_WD, 32'hD000_0001);
    tick();
    grant("t2_s0b", 3'b001, 2'b10, 32'h0000_1000); push("t2_wd2", S_WD, 32'hD000_0002);
    tick();

    // INCR4 burst from S1 with a BUSY beat; S0/S2 contend
    do_reset();
    req(1, 2'b10, 32'h0000_0100, 32'h1111_0000, 1'b0);
    bu[1] = 3'b011;
    grant("t3_nseq", 3'b010, 2'b10, 32'h0000_0100);
    tick();
    grant("t3_nseq_acc", 3'b010, 2'b10, 32'h0000_0100);
    tick();
    req(0, 2'b10, 32'h0000_1000, 32'h0, 1'b0);
    req(2, 2'b10, 32'h0000_3000, 32'h0, 1'b0);
    tr[1] = 2'b11; ad[1] = 32'h0000_0104;
    grant("t3_seq1", 3'b010, 2'b11, 32'h0000_0104);
    tick();
    tr[1] = 2'b01; ad[1] = 32'h0000_0108;
    grant("t3_busy", 3'b010, 2'b01, 32'h0000_0108);
    tick();
    tr[1] = 2'b11;
    grant("t3_seq2", 3'b010, 2'b11, 32'h0000_0108);
    tick();
    ad[1] = 32'h0000_010C;
    grant("t3_seq3", 3'b010, 2'b11, 32'h0000_010C);
    tick();
    sel[1] = 1'b0; tr[1] = 2'b00;
    grant("t3_next_s2", 3'b100, 2'b10, 32'h0000_3000);
    tick();

    // locked sequence from S2 with IDLE gaps while S0 requests
    do_reset();
    lock_tr = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    lock_ad = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h208};
    req(2, 2'b10, 32'h0000_0200, 32'h0, 1'b1);
    grant("t4_s2", 3'b100, 2'b10, 32'h0000_0200); push("t4_lock", S_LK, 1);
    tick();
    req(0, 2'b10, 32'h0000_1000, 32'h0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      tr[2] = lock_tr[b]; ad[2] = lock_ad[b];
      grant($sformatf("t4_hold%0d", b), 3'b100, lock_tr[b], lock_ad[b]);
      push($sformatf("t4_lock%0d", b), S_LK, 1);
      tick();
    end
    tr[2] = 2'b00; lk[2] = 1'b0;
    grant("t4_s0", 3'b001, 2'b10, 32'h0000_1000); push("t4_unlock", S_LK, 0);
    tick();

    // wait states during a write data phase
    do_reset();
    req(0, 2'b10, 32'h0000_0300, 32'hCAFE_0005, 1'b0);
    grant("t5_g", 3'b001, 2'b10, 32'h0000_0300);
    tick();
    push("t5_act", S_ACT, 3'b001); push("t5_wd", S_WD, 32'hCAFE_0005);
    tick();
    sel[0] = 1'b0; tr[0] = 2'b00;
    HREADYM = 1'b0;
    req(1, 2'b10, 32'h0000_0400, 32'h0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      push($sformatf("t5_stall_act%0d", w), S_ACT, 3'b001);
      push($sformatf("t5_stall_wd%0d", w), S_WD, 32'hCAFE_0005);
      push($sformatf("t5_stall_addr%0d", w), S_ADDR, 32'h0000_0300);
      tick();
    end
    HREADYM = 1'b1;
    grant("t5_s1", 3'b010, 2'b10, 32'h0000_0400); push("t5_wd_done", S_WD, 0);
    tick();

    // reset in the middle of an S1 burst
    do_reset();
    req(1, 2'b10, 32'h0000_0500, 32'hBEEF_0001, 1'b0);
    grant("t6_g", 3'b010, 2'b10, 32'h0000_0500);
    tick();
    push("t6_wd", S_WD, 32'hBEEF_0001);
    tick();
    tr[1] = 2'b11; ad[1] = 32'h0000_0504;
    #2;
    HRESETn = 1'b0;
    #1;
    push("t6_act", S_ACT, 0); push("t6_hsel", S_SEL, 0);
    push("t6_htrans", S_TR, 0); push("t6_hwdata", S_WD, 0);
    drain();
    tr[1] = 2'b10;
    req(0, 2'b10, 32'h0000_0600, 32'h0, 1'b0);
    #1;
    HRESETn = 1'b1;
    grant("t6_s0_first", 3'b001, 2'b10, 32'h0000_0600);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
